// File: rtl/rv_regfile_pkg.sv
// Shared types and default sizing for the atomRVCORE integer register file.
package rv_regfile_pkg;

  localparam int DATAWIDTH        = 32;
  localparam int REGISTERS        = 32;
  localparam int REG_ADRESS_WIDTH = $clog2(REGISTERS);

  typedef logic [REG_ADRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DATAWIDTH-1:0]        reg_data_t;

  // One writeback request as seen by the register file
  typedef struct packed {
    logic      we;
    reg_addr_t rd;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/rv_regfile_scoreboard_if.sv
// Decode/issue/writeback bundle between the core pipeline (master) and the
// register file with scoreboard (slave).
interface rv_regfile_scoreboard_if #(
  parameter int DATAWIDTH        = 32,
  parameter int REG_ADRESS_WIDTH = 5,
  parameter int NUM_READ         = 2
);

  logic [NUM_READ-1:0][REG_ADRESS_WIDTH-1:0] rs_addr_i;
  logic [NUM_READ-1:0][DATAWIDTH-1:0]        rs_data_o;
  logic [NUM_READ-1:0]                       rs_ready_o;
  logic                                      iss_valid_i;
  logic [REG_ADRESS_WIDTH-1:0]               iss_rd_i;
  logic                                      iss_ready_o;
  logic                                      alu_we_i;
  logic [REG_ADRESS_WIDTH-1:0]               alu_rd_i;
  logic [DATAWIDTH-1:0]                      alu_data_i;
  logic                                      ld_we_i;
  logic [REG_ADRESS_WIDTH-1:0]               ld_rd_i;
  logic [DATAWIDTH-1:0]                      ld_data_i;
  logic                                      flush_i;
  logic                                      wb_err_o;

  modport master (
    output rs_addr_i, iss_valid_i, iss_rd_i,
    output alu_we_i, alu_rd_i, alu_data_i,
    output ld_we_i, ld_rd_i, ld_data_i, flush_i,
    input  rs_data_o, rs_ready_o, iss_ready_o, wb_err_o
  );

  modport slave (
    input  rs_addr_i, iss_valid_i, iss_rd_i,
    input  alu_we_i, alu_rd_i, alu_data_i,
    input  ld_we_i, ld_rd_i, ld_data_i, flush_i,
    output rs_data_o, rs_ready_o, iss_ready_o, wb_err_o
  );

endinterface

// File: rtl/rv_rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking an
// in-flight destination. Priority at the edge: flush > issue set > write clear.
module rv_rf_scoreboard #(
  parameter int REGISTERS        = 32,
  parameter int REG_ADRESS_WIDTH = 5,
  parameter int NUM_READ         = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      iss_valid_i,
  input  logic [REG_ADRESS_WIDTH-1:0]               iss_rd_i,
  input  logic [1:0]                                wr_en_i,   // already qualified with rd != 0
  input  logic [1:0][REG_ADRESS_WIDTH-1:0]          wr_rd_i,
  input  logic                                      flush_i,
  input  logic [NUM_READ-1:0][REG_ADRESS_WIDTH-1:0] rs_addr_i,
  output logic                                      iss_ready_o,
  output logic [NUM_READ-1:0]                       rs_pending_o,
  output logic [REGISTERS-1:0]                      busy_o
);
  import rv_regfile_pkg::*;

  logic [REGISTERS-1:0] busy_q, busy_d;
  logic                 wr_hits_iss;

  // Issue acceptance: free destination, x0, or the blocking writer retires now
  always_comb begin
    wr_hits_iss = (wr_en_i[0] && (wr_rd_i[0] == iss_rd_i)) ||
                  (wr_en_i[1] && (wr_rd_i[1] == iss_rd_i));
    iss_ready_o = (iss_rd_i == '0) || !busy_q[iss_rd_i] || wr_hits_iss;
  end

  // Next busy vector; later assignments override earlier ones
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < 2; w++) begin
      if (wr_en_i[w]) busy_d[wr_rd_i[w]] = 1'b0;
    end
    if (iss_valid_i && iss_ready_o && (iss_rd_i != '0)) busy_d[iss_rd_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy register, cleared by reset so every destination reads free
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // Per read port: operand still owned by an in-flight instruction
  always_comb begin
    rs_pending_o = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rs_pending_o[k] = (rs_addr_i[k] != '0) && busy_q[rs_addr_i[k]];
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rv_regfile_scoreboard.sv
// Integer register file with NUM_READ combinational read ports, ALU and load
// writeback ports, and a busy-bit scoreboard. x0 is hardwired zero.
// Optional macro RV_RF_BYPASS_EN: forwards same-cycle writeback data to the
// read ports and reports those operands ready (load data beats ALU data).
module rv_regfile_scoreboard #(
  parameter int DATAWIDTH        = 32,
  parameter int REGISTERS        = 32,
  parameter int REG_ADRESS_WIDTH = $clog2(REGISTERS),
  parameter int NUM_READ         = 2
) (
  input  logic                   clk_i,
  input  logic                   regrst_ni,
  rv_regfile_scoreboard_if.slave rf
);
  import rv_regfile_pkg::*;

  logic [DATAWIDTH-1:0] regs_q [REGISTERS];
  logic [DATAWIDTH-1:0] regs_d [REGISTERS];
  logic                 wb_err_q, wb_err_d;
  logic                 alu_wr, ld_wr;
  logic [REGISTERS-1:0] busy;
  logic [NUM_READ-1:0]  rs_pending;
  logic                 iss_ready;

  // Writes to x0 are dropped here so nothing downstream sees them
  assign alu_wr = rf.alu_we_i && (rf.alu_rd_i != '0);
  assign ld_wr  = rf.ld_we_i  && (rf.ld_rd_i  != '0);

  rv_rf_scoreboard #(
    .REGISTERS        (REGISTERS),
    .REG_ADRESS_WIDTH (REG_ADRESS_WIDTH),
    .NUM_READ         (NUM_READ)
  ) u_sb (
    .clk_i        (clk_i),
    .rst_ni       (regrst_ni),
    .iss_valid_i  (rf.iss_valid_i),
    .iss_rd_i     (rf.iss_rd_i),
    .wr_en_i      ({ld_wr, alu_wr}),
    .wr_rd_i      ({rf.ld_rd_i, rf.alu_rd_i}),
    .flush_i      (rf.flush_i),
    .rs_addr_i    (rf.rs_addr_i),
    .iss_ready_o  (iss_ready),
    .rs_pending_o (rs_pending),
    .busy_o       (busy)
  );

  // Write arbitration: load is applied last so it wins a same-rd collision
  always_comb begin
    regs_d = regs_q;
    if (alu_wr) regs_d[rf.alu_rd_i] = rf.alu_data_i;
    if (ld_wr)  regs_d[rf.ld_rd_i]  = rf.ld_data_i;
    regs_d[0] = '0;
  end

  // Sticky error: write collision, or writeback to a register nobody owns
  always_comb begin
    wb_err_d = wb_err_q;
    if (alu_wr && ld_wr && (rf.alu_rd_i == rf.ld_rd_i)) wb_err_d = 1'b1;
    if (alu_wr && !busy[rf.alu_rd_i])                    wb_err_d = 1'b1;
    if (ld_wr  && !busy[rf.ld_rd_i])                     wb_err_d = 1'b1;
  end

  // Register storage and error flag
  always_ff @(posedge clk_i or negedge regrst_ni) begin
    if (!regrst_ni) begin
      for (int i = 0; i < REGISTERS; i++) regs_q[i] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      wb_err_q <= wb_err_d;
    end
  end

  // Read ports, with optional same-cycle forwarding of writeback data
  always_comb begin
    rf.rs_data_o  = '0;
    rf.rs_ready_o = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rf.rs_data_o[k]  = (rf.rs_addr_i[k] == '0) ? '0 : regs_q[rf.rs_addr_i[k]];
      rf.rs_ready_o[k] = !rs_pending[k];
`ifdef RV_RF_BYPASS_EN
      if (ld_wr && (rf.ld_rd_i == rf.rs_addr_i[k])) begin
        rf.rs_data_o[k]  = rf.ld_data_i;
        rf.rs_ready_o[k] = 1'b1;
      end else if (alu_wr && (rf.alu_rd_i == rf.rs_addr_i[k])) begin
        rf.rs_data_o[k]  = rf.alu_data_i;
        rf.rs_ready_o[k] = 1'b1;
      end
`else
`endif
    end
  end

  assign rf.iss_ready_o = iss_ready;
  assign rf.wb_err_o    = wb_err_q;

endmodule

// File: tb/tb_rv_regfile_scoreboard.sv
// Table-driven bench for rv_regfile_scoreboard. Each table row is one clock
// cycle of inputs plus the outputs expected in that same cycle. Expected
// records are queued when a row is driven and popped when outputs are sampled.
module tb_rv_regfile_scoreboard;
  import rv_regfile_pkg::*;

`ifdef RV_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int NROWS = 29;

  typedef struct {
    reg_addr_t rs0, rs1;
    logic      iv;
    reg_addr_t ird;
    logic      awe;
    reg_addr_t ard;
    reg_data_t adat;
    logic      lwe;
    reg_addr_t lrd;
    reg_data_t ldat;
    logic      fl;
    reg_data_t e_d0, e_d1;
    logic [1:0] e_rdy;
    logic      e_irdy, e_err;
  } vec_t;

  typedef struct {
    int         idx;
    reg_data_t  d0, d1;
    logic [1:0] rdy;
    logic       irdy, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NROWS];
  exp_t expq [$];

  always #5 clk = ~clk;

  rv_regfile_scoreboard_if #(.DATAWIDTH(32), .REG_ADRESS_WIDTH(5), .NUM_READ(2)) bus ();

  rv_regfile_scoreboard #(
    .DATAWIDTH(32), .REGISTERS(32), .REG_ADRESS_WIDTH(5), .NUM_READ(2)
  ) dut (
    .clk_i     (clk),
    .regrst_ni (rst_n),
    .rf        (bus)
  );

  function automatic vec_t mk(int rs0, int rs1, bit iv, int ird,
                              bit awe, int ard, reg_data_t adat,
                              bit lwe, int lrd, reg_data_t ldat, bit fl,
                              reg_data_t e_d0, reg_data_t e_d1, logic [1:0] e_rdy,
                              bit e_irdy, bit e_err);
    vec_t v;
    v.rs0 = reg_addr_t'(rs0);  v.rs1 = reg_addr_t'(rs1);
    v.iv = iv;                 v.ird = reg_addr_t'(ird);
    v.awe = awe;               v.ard = reg_addr_t'(ard);  v.adat = adat;
    v.lwe = lwe;               v.lrd = reg_addr_t'(lrd);  v.ldat = ldat;
    v.fl = fl;
    v.e_d0 = e_d0;  v.e_d1 = e_d1;  v.e_rdy = e_rdy;
    v.e_irdy = e_irdy;  v.e_err = e_err;
    return v;
  endfunction

  // Expected read value that depends on whether forwarding is compiled in
  function automatic reg_data_t bsel(reg_data_t with_byp, reg_data_t without_byp);
    return BYP ? with_byp : without_byp;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic sample_pop();
    exp_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL queue: no expected record available");
      return;
    end
    e = expq.pop_front();
    check("rs_data0", e.idx, bus.rs_data_o[0], e.d0);
    check("rs_data1", e.idx, bus.rs_data_o[1], e.d1);
    check("rs_ready", e.idx, 32'(bus.rs_ready_o), 32'(e.rdy));
    check("iss_ready", e.idx, 32'(bus.iss_ready_o), 32'(e.irdy));
    check("wb_err", e.idx, 32'(bus.wb_err_o), 32'(e.err));
  endtask

  task automatic drive_idle();
    bus.rs_addr_i   = '0;
    bus.iss_valid_i = 1'b0;  bus.iss_rd_i = '0;
    bus.alu_we_i    = 1'b0;  bus.alu_rd_i = '0;  bus.alu_data_i = '0;
    bus.ld_we_i     = 1'b0;  bus.ld_rd_i  = '0;  bus.ld_data_i  = '0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic run_row(int i);
    exp_t e;
    @(negedge clk);
    bus.rs_addr_i[0] = vecs[i].rs0;   bus.rs_addr_i[1] = vecs[i].rs1;
    bus.iss_valid_i  = vecs[i].iv;    bus.iss_rd_i     = vecs[i].ird;
    bus.alu_we_i     = vecs[i].awe;   bus.alu_rd_i     = vecs[i].ard;
    bus.alu_data_i   = vecs[i].adat;
    bus.ld_we_i      = vecs[i].lwe;   bus.ld_rd_i      = vecs[i].lrd;
    bus.ld_data_i    = vecs[i].ldat;
    bus.flush_i      = vecs[i].fl;
    e.idx = i;  e.d0 = vecs[i].e_d0;  e.d1 = vecs[i].e_d1;
    e.rdy = vecs[i].e_rdy;  e.irdy = vecs[i].e_irdy;  e.err = vecs[i].e_err;
    expq.push_back(e);
    #2;
    sample_pop();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must return to reset values
  // immediately, with reads and issue aimed at a register that held state.
  task automatic reset_check(int addr, int tag);
    exp_t e;
    @(negedge clk);
    drive_idle();
    bus.rs_addr_i[0] = reg_addr_t'(addr);
    bus.rs_addr_i[1] = reg_addr_t'(addr);
    bus.iss_rd_i     = reg_addr_t'(addr);
    #2;
    rst_n = 1'b0;
    e.idx = tag;  e.d0 = '0;  e.d1 = '0;  e.rdy = 2'b11;  e.irdy = 1'b1;  e.err = 1'b0;
    expq.push_back(e);
    #1;
    sample_pop();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            rs0 rs1 iv ird awe ard adat           lwe lrd ldat          fl  e_d0                               e_d1           rdy            irdy err
    vecs[0]  = mk(0,  5,  0, 0,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[1]  = mk(7,  0,  1, 7,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[2]  = mk(7,  7,  0, 7,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b00,         0,   0);
    vecs[3]  = mk(7,  0,  0, 7,  1,  7,  32'h1234,      0,  0,  0,            0,  bsel(32'h1234, 0),                 0,             {1'b1, BYP},   1,   0);
    vecs[4]  = mk(7,  7,  0, 0,  0,  0,  0,             0,  0,  0,            0,  32'h1234,                          32'h1234,      2'b11,         1,   0);
    vecs[5]  = mk(3,  7,  1, 3,  0,  0,  0,             0,  0,  0,            0,  0,                                 32'h1234,      2'b11,         1,   0);
    vecs[6]  = mk(3,  7,  1, 3,  0,  0,  0,             0,  0,  0,            0,  0,                                 32'h1234,      2'b10,         0,   0);
    vecs[7]  = mk(3,  7,  1, 3,  0,  0,  0,             1,  3,  32'hCAFE,     0,  bsel(32'hCAFE, 0),                 32'h1234,      {1'b1, BYP},   1,   0);
    vecs[8]  = mk(3,  3,  0, 3,  0,  0,  0,             0,  0,  0,            0,  32'hCAFE,                          32'hCAFE,      2'b00,         0,   0);
    vecs[9]  = mk(3,  0,  0, 0,  0,  0,  0,             1,  3,  32'hBEEF,     0,  bsel(32'hBEEF, 32'hCAFE),          0,             {1'b1, BYP},   1,   0);
    vecs[10] = mk(0,  0,  1, 0,  1,  0,  32'hFFFFFFFF,  0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[11] = mk(0,  3,  0, 0,  0,  0,  0,             0,  0,  0,            0,  0,                                 32'hBEEF,      2'b11,         1,   0);
    vecs[12] = mk(0,  0,  1, 1,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[13] = mk(0,  0,  1, 2,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[14] = mk(1,  2,  1, 31, 0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b00,         1,   0);
    vecs[15] = mk(31, 4,  1, 4,  0,  0,  0,             0,  0,  0,            1,  0,                                 0,             2'b10,         1,   0);
    vecs[16] = mk(31, 4,  0, 1,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[17] = mk(7,  3,  0, 0,  0,  0,  0,             0,  0,  0,            0,  32'h1234,                          32'hBEEF,      2'b11,         1,   0);
    vecs[18] = mk(5,  0,  1, 5,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[19] = mk(5,  0,  0, 0,  1,  5,  32'hDEADBEEF,  0,  0,  0,            0,  bsel(32'hDEADBEEF, 0),             0,             {1'b1, BYP},   1,   0);
    vecs[20] = mk(5,  0,  1, 5,  0,  0,  0,             0,  0,  0,            0,  32'hDEADBEEF,                      0,             2'b11,         1,   0);
    vecs[21] = mk(5,  5,  0, 5,  0,  0,  0,             0,  0,  0,            0,  32'hDEADBEEF,                      32'hDEADBEEF,  2'b00,         0,   0);
    vecs[22] = mk(10, 0,  0, 0,  1,  10, 32'h10,        0,  0,  0,            0,  bsel(32'h10, 0),                   0,             2'b11,         1,   0);
    vecs[23] = mk(10, 0,  0, 0,  0,  0,  0,             0,  0,  0,            0,  32'h10,                            0,             2'b11,         1,   1);
    vecs[24] = mk(5,  0,  0, 0,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   1);
    vecs[25] = mk(9,  0,  1, 9,  0,  0,  0,             0,  0,  0,            0,  0,                                 0,             2'b11,         1,   0);
    vecs[26] = mk(9,  0,  0, 0,  1,  9,  32'hAAAAAAAA,  1,  9,  32'h55555555, 0,  bsel(32'h55555555, 0),             0,             {1'b1, BYP},   1,   0);
    vecs[27] = mk(9,  0,  0, 0,  0,  0,  0,             0,  0,  0,            0,  32'h55555555,                      0,             2'b11,         1,   1);
    vecs[28] = mk(9,  9,  0, 0,  0,  0,  0,             0,  0,  0,            0,  32'h55555555,                      32'h55555555,  2'b11,         1,   1);

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic issue/writeback, WAW stall, x0 handling, flush, then load x5 busy
    for (int i = 0; i <= 21; i++) run_row(i);
    // x5 holds DEADBEEF and is busy: reset must wipe data, busy and error
    reset_check(5, 100);
    // Writeback to a free register raises the sticky error
    for (int i = 22; i <= 24; i++) run_row(i);
    reset_check(10, 101);
    // Dual-port collision on x9: load wins, error sets and stays
    for (int i = 25; i <= 28; i++) run_row(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_regfile_scoreboard.md
# rv_regfile_scoreboard

Parametrised integer register file for the atomRVCORE pipeline. It generalises the single-write, two-read file to N combinational read ports and two independent writeback ports: ALU and load. A per-register scoreboard of busy bits tracks in-flight destinations, blocks WAW issue, and flags operands that are not yet ready. Decode, issue and writeback connect to it directly, and it replaces the legacy file in the core.

## Interface
Parameters:
- DATAWIDTH, 32, width of each register and of all data ports
- REGISTERS, 32, number of architectural registers; index 0 is hardwired zero
- REG_ADRESS_WIDTH, $clog2(REGISTERS), width of every register address port
- NUM_READ, 2, number of read ports (1..4)

Ports:
- clk_i  in  1  clock, rising edge
- regrst_ni  in  1  asynchronous reset, active low
- rs_addr_i  in  NUM_READ x REG_ADRESS_WIDTH  read addresses
- rs_data_o  out  NUM_READ x DATAWIDTH  read data, combinational
- rs_ready_o  out  NUM_READ  operand valid, not pending
- iss_valid_i  in  1  instruction issuing with a destination
- iss_rd_i  in  REG_ADRESS_WIDTH  destination of the issuing instruction
- iss_ready_o  out  1  issue accepted (issue handshake fires when valid && ready)
- alu_we_i, alu_rd_i, alu_data_i  in  1 / REG_ADRESS_WIDTH / DATAWIDTH  ALU writeback (write port 0)
- ld_we_i, ld_rd_i, ld_data_i  in  1 / REG_ADRESS_WIDTH / DATAWIDTH  load writeback (write port 1)
- flush_i  in  1  clear all busy bits; register data is untouched
- wb_err_o  out  1  sticky error flag

## Operation
- Storage: REGISTERS x DATAWIDTH flops.
- Register 0:
  - Reads as 0 and is always ready.
  - Writes to it are discarded.
  - Issue to it never sets busy.
- Writes:
  - Each asserted write port with rd != 0 writes its data at the clock edge.
  - If both ports target the same rd in one cycle, the load port data wins and wb_err_o sets.
- Busy bits:
  - busy[rd] sets on an issue handshake with rd != 0.
  - busy[rd] clears on any write to rd.
  - Issue and write to the same rd in one cycle: the set wins and busy stays 1. The new instruction owns rd.
  - A write to a register whose busy bit is 0 still updates the data and sets wb_err_o.
- iss_ready_o is 1 when any of the following holds:
  - iss_rd_i == 0;
  - busy[iss_rd_i] == 0;
  - a write to iss_rd_i occurs this cycle.
  Otherwise it is 0 (WAW stall).
- rs_ready_o[k] is 1 when any of the following holds:
  - rs_addr_i[k] == 0;
  - busy[rs_addr_i[k]] == 0;
  - a same-cycle write to that address occurs and bypass is compiled in (see Configuration).
- rs_data_o[k]:
  - Returns the stored value.
  - With bypass, returns the same-cycle write data instead. Load port has priority over ALU.
- flush_i:
  - Clears every busy bit at the edge.
  - Has priority over a same-cycle issue set, so busy ends at 0.
  - Writes in the same cycle still update data.
- wb_err_o clears only on reset.

## Timing
- Reset (asynchronous, regrst_ni low):
  - All registers 0, all busy 0, wb_err_o 0.
  - Outputs: rs_data_o = 0, rs_ready_o = all 1, iss_ready_o = 1.
- Reads are combinational from the addresses.
- Write-to-read latency:
  - 1 cycle without bypass.
  - 0 cycles with bypass.
- Issue at edge n: busy is visible from cycle n+1.
- Writeback at edge n:
  - busy is clear from cycle n+1.
  - iss_ready_o for the same rd is already 1 in cycle n.
- Reset deasserting mid-operation: all pending destinations are lost. The core must flush in-flight writebacks.

## Configuration
- RV_RF_BYPASS_EN defined:
  - Same-cycle write data forwards to rs_data_o.
  - rs_ready_o includes same-cycle writes.
- Not defined:
  - No forwarding path.
  - rs_ready_o = !busy or register 0.
  - Operands written this cycle read ready one cycle later.
  - Saves NUM_READ x 2 comparators and muxes.

## Structure
- Package rv_regfile_pkg holds:
  - localparams DATAWIDTH, REGISTERS, REG_ADRESS_WIDTH;
  - typedef reg_addr_t;
  - typedef reg_data_t;
  - typedef struct wb_req_t {we, rd, data}.
- Sub-module rv_rf_scoreboard owns:
  - the busy vector, set/clear/flush priority, iss_ready_o and per-port pending flags.
- The top holds the data array, write arbitration, bypass muxes and wb_err_o.

## Test plan
- Reset mid-run with x5 = 32'hDEADBEEF and busy[5] = 1 -> x5 reads 0, rs_ready_o all 1, wb_err_o 0.
- Issue rd = 7, then read x7 -> rs_ready_o 0. ALU writes 32'h1234 to x7 at cycle n.
  - With bypass: rs_data_o = 32'h1234 and ready in cycle n.
  - Without bypass: ready in cycle n+1.
- Issue rd = 3 while busy[3] = 1 -> iss_ready_o 0. In the cycle the load writes x3, iss_ready_o = 1, and busy[3] ends at 1.
- Both ports write x9 (ALU 32'hAAAA_AAAA, load 32'h5555_5555) -> x9 = 32'h5555_5555, wb_err_o = 1, and it stays set.
- Issue rd = 0 and write 32'hFFFF_FFFF to x0 -> x0 reads 0, iss_ready_o stays 1, busy never sets.
- Busy on x1, x2, x31, then flush_i together with an issue to rd = 4 -> all busy 0 next cycle and register data unchanged.
